// File: rtl/seven_seg_scanner_if.sv
// Value-update handshake between system logic and the seven-segment scanner.
// The master presents a hex value plus decimal points; the slave accepts it when ready.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic                    value_valid_i;
  logic                    value_ready_o;

  modport master (
    output value_i,
    output dp_i,
    output value_valid_i,
    input  value_ready_o
  );

  modport slave (
    input  value_i,
    input  dp_i,
    input  value_valid_i,
    output value_ready_o
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with dead-time between digits.
// Value updates are staged in a pending register and applied only at frame wraps.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scanner_if.slave    upd,
  input  logic [NUM_DIGITS-1:0] digit_en_i,
  input  logic                  lz_blank_i,
  output logic [6:0]            segs_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  frame_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VAL_W-1:0]        active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [VAL_W-1:0]        pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              segs_q, segs_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;
  logic                    slot_end, frame_wrap;

  function automatic logic [6:0] hex_to_segs(input logic [3:0] h);
    case (h)
      4'h0: hex_to_segs = 7'h40;
      4'h1: hex_to_segs = 7'h79;
      4'h2: hex_to_segs = 7'h24;
      4'h3: hex_to_segs = 7'h30;
      4'h4: hex_to_segs = 7'h19;
      4'h5: hex_to_segs = 7'h12;
      4'h6: hex_to_segs = 7'h02;
      4'h7: hex_to_segs = 7'h78;
      4'h8: hex_to_segs = 7'h00;
      4'h9: hex_to_segs = 7'h10;
      4'hA: hex_to_segs = 7'h08;
      4'hB: hex_to_segs = 7'h03;
      4'hC: hex_to_segs = 7'h46;
      4'hD: hex_to_segs = 7'h21;
      4'hE: hex_to_segs = 7'h06;
      default: hex_to_segs = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      an_q         <= '1;
      segs_q       <= 7'h7F;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      an_q         <= an_d;
      segs_q       <= segs_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  always_comb begin
    slot_end   = (cnt_q == CNT_W'(CLK_DIV - 1));
    frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (slot_end) idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
    state_d    = (cnt_d < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;

    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    // A capture needs an empty pending slot, so it can never collide with the
    // wrap-time copy; a capture in the wrap cycle waits for the next wrap.
    if (frame_wrap && pend_vld_q) begin
      active_val_d = pend_val_q;
      active_dp_d  = pend_dp_q;
      pend_vld_d   = 1'b0;
    end
    if (upd.value_valid_i && !pend_vld_q) begin
      pend_val_d = upd.value_i;
      pend_dp_d  = upd.dp_i;
      pend_vld_d = 1'b1;
    end
  end

  logic [3:0] cur_digit;
  logic       lz_hit;
  logic       blanked;

  always_comb begin
    cur_digit = active_val_q[{idx_q, 2'b00} +: 4];
    // Shifting out the lower digits leaves zero only if this digit and all above are zero.
    lz_hit    = lz_blank_i && (idx_q != '0) &&
                ((active_val_q >> {idx_q, 2'b00}) == '0);
    blanked   = !digit_en_i[idx_q] || lz_hit;
    an_d      = '1;
    segs_d    = 7'h7F;
    dp_d      = 1'b1;
    frame_d   = frame_wrap;
    if (state_q == ST_DRIVE && !blanked) begin
      an_d[idx_q] = 1'b0;
      segs_d      = hex_to_segs(cur_digit);
      dp_d        = ~active_dp_q[idx_q];
    end
  end

  assign an_o              = an_q;
  assign segs_o            = segs_q;
  assign dp_o              = dp_q;
  assign frame_o           = frame_q;
  assign upd.value_ready_o = ~pend_vld_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner: a cycle-count reference model predicts
// every output from slot/digit arithmetic and the staged-update rules.
module tb_seven_seg_scanner;
  localparam int N  = 4;
  localparam int D  = 10;
  localparam int BL = 2;
  localparam int FRAME = N * D;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] digit_en_i;
  logic         lz_blank_i;
  logic [6:0]   segs_o;
  logic         dp_o;
  logic [N-1:0] an_o;
  logic         frame_o;

  seven_seg_scanner_if #(.NUM_DIGITS(N)) upd ();

  seven_seg_scanner #(.NUM_DIGITS(N), .CLK_DIV(D), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .upd(upd),
    .digit_en_i(digit_en_i), .lz_blank_i(lz_blank_i),
    .segs_o(segs_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the coming cycle.
  logic         s_valid;
  logic [15:0]  s_value;
  logic [N-1:0] s_dp, s_en;
  logic         s_lz;

  // Reference model state.
  int           k;
  logic [15:0]  act_v, pend_v;
  logic [N-1:0] act_dp, pend_dp;
  bit           pend;
  logic [N-1:0] e_an;
  logic [6:0]   e_segs;
  logic         e_dp, e_frame;

  task automatic model_reset();
    k = 0; act_v = '0; act_dp = '0; pend = 0; pend_v = '0; pend_dp = '0;
    e_an = '1; e_segs = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_val("an",    32'(an_o),   32'(e_an));
    check_val("segs",  32'(segs_o), 32'(e_segs));
    check_val("dp",    32'(dp_o),   32'(e_dp));
    check_val("frame", 32'(frame_o), 32'(e_frame));
    check_val("ready", 32'(upd.value_ready_o), 32'(!pend));
  endtask

  task automatic drive();
    upd.value_valid_i = s_valid;
    upd.value_i       = s_value;
    upd.dp_i          = s_dp;
    digit_en_i        = s_en;
    lz_blank_i        = s_lz;
  endtask

  // Predict outputs for the cycle after k, then apply this cycle's update rules.
  task automatic commit();
    int c, i;
    bit wrap, xfer, blank;
    c = k % D;
    i = (k / D) % N;
    blank = !s_en[i] || (s_lz && i != 0 && ((act_v >> (4 * i)) == 16'h0));
    if (c < BL || blank) begin
      e_an = '1; e_segs = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an = ~(N'(1) << i);
      e_segs = glyph[(act_v >> (4 * i)) & 16'hF];
      e_dp = ~act_dp[i];
    end
    wrap = (c == D - 1) && (i == N - 1);
    e_frame = wrap;
    xfer = s_valid && !pend;
    if (wrap && pend) begin
      act_v = pend_v; act_dp = pend_dp; pend = 0;
    end
    if (xfer) begin
      pend = 1; pend_v = s_value; pend_dp = s_dp;
    end
    k++;
  endtask

  task automatic cyc();
    tick();
    drive();
    commit();
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) cyc();
  endtask

  task automatic run_to(input int phase);
    for (int j = 0; j < FRAME && (k % FRAME) != phase; j++) cyc();
  endtask

  task automatic load(input logic [15:0] v, input logic [N-1:0] dpv);
    s_valid = 1'b1; s_value = v; s_dp = dpv;
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_an",    32'(an_o),   32'hF);
    check_val("rst_segs",  32'(segs_o), 32'h7F);
    check_val("rst_dp",    32'(dp_o),   32'h1);
    check_val("rst_frame", 32'(frame_o), 32'h0);
    check_val("rst_ready", 32'(upd.value_ready_o), 32'h1);
    model_reset();
    repeat (2) @(negedge clk);
    tick();
    rst_n = 1'b1;
    drive();
    commit();
  endtask

  initial begin
    s_valid = 1'b0; s_value = '0; s_dp = '0; s_en = '1; s_lz = 1'b0;
    drive();
    model_reset();
    #3;
    do_reset();
    run(45);

    // Mid-frame load, displayed from the next frame on.
    run_to(15);
    load(16'h1234, 4'b0000);
    run(100);

    // Leading-zero blanking on and off.
    s_lz = 1'b1;
    load(16'h0005, 4'b0000);
    run(90);
    s_lz = 1'b0;
    run(40);

    // Transfer landing exactly in the wrap cycle waits a full extra frame.
    run_to(FRAME - 1);
    load(16'hABCD, 4'b0000);
    run(100);

    // Per-digit enable and decimal point.
    s_en = 4'b0101;
    load(16'h9876, 4'b0001);
    run(100);
    s_en = '1;

    // Randomized traffic.
    for (int j = 0; j < 2000; j++) begin
      s_valid = ($urandom_range(0, 3) == 0);
      if (s_valid) begin
        s_value = 16'($urandom);
        s_dp    = N'($urandom);
      end
      if ($urandom_range(0, 49) == 0) s_en = N'($urandom);
      if ($urandom_range(0, 49) == 0) s_lz = 1'($urandom);
      if ($urandom_range(0, 7) == 0) s_value = s_value & 16'h000F;
      cyc();
    end
    s_valid = 1'b0; s_en = '1; s_lz = 1'b0;
    run(FRAME + 5);

    // Reset while digit 2 drives and an update is pending.
    run_to(1);
    load(16'h4321, 4'b1111);
    run_to(25);
    @(posedge clk);
    #2;
    do_reset();
    run(90);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
